// File: rtl/SOPHON_PKG.sv
// Shared LSU request/response payloads for the core data interface.
package SOPHON_PKG;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned AMO_W  = 4;
    localparam int unsigned SIZE_W = 2;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [AMO_W-1:0]  amo;
        logic [STRB_W-1:0] strb;
        logic [SIZE_W-1:0] size;
    } lsu_req_t;

    typedef struct packed {
        logic              ack;
        logic              error;
        logic [DATA_W-1:0] rdata;
    } lsu_ack_t;

    // Quiescent channel payload: everything zero except size.
    localparam lsu_req_t LSU_REQ_IDLE = '{req: 1'b0, we: 1'b0, addr: '0, wdata: '0,
                                          amo: '0, strb: '0, size: SIZE_W'(1)};
    localparam lsu_ack_t LSU_ACK_IDLE = '{ack: 1'b0, error: 1'b0, rdata: '0};
    localparam lsu_ack_t LSU_ACK_ERR  = '{ack: 1'b1, error: 1'b1, rdata: '0};

endpackage

// File: rtl/lsu_itf_demux_nch.sv
// N-channel LSU address-window demux with per-channel combinational or registered ports.
// Optional hung-channel watchdog enabled by defining LSU_DEMUX_TIMEOUT_EN.
module lsu_itf_demux_nch #(
    parameter int unsigned NUM_CH = 4,
    parameter logic [31:0] CH_BASE [NUM_CH] = '{32'h10000, 32'h90000, 32'hA0000, 32'hB0000},
    parameter logic [31:0] CH_END  [NUM_CH] = '{32'h1ffff, 32'h9ffff, 32'hAffff, 32'hBffff},
    parameter logic [NUM_CH-1:0] CH_REG = 4'b1110
`ifdef LSU_DEMUX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  SOPHON_PKG::lsu_req_t lsu_req_i,
    output SOPHON_PKG::lsu_ack_t lsu_ack_o,
    output SOPHON_PKG::lsu_req_t lsu_req_ch_o [NUM_CH],
    input  SOPHON_PKG::lsu_ack_t lsu_ack_ch_i [NUM_CH],
    output logic                 busy_o
);

    import SOPHON_PKG::*;

    typedef enum logic [1:0] {IDLE, REG_WAIT, ERR_RESP} state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   hit, sel, sel_q, sel_d;
    logic                ld_reg, clr_reg;
    lsu_ack_t            ack_comb, ack_sel;

`ifdef LSU_DEMUX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Page-granular window decode; lowest index wins on overlap.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (lsu_req_i.addr[31:12] >= CH_BASE[i][31:12]) &&
                     (lsu_req_i.addr[31:12] <= CH_END[i][31:12]);
        end
        sel = hit & (~hit + NUM_CH'(1));
    end

    always_comb begin
        ack_comb = LSU_ACK_IDLE;
        ack_sel  = LSU_ACK_IDLE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i])   ack_comb = lsu_ack_ch_i[i];
            if (sel_q[i]) ack_sel  = lsu_ack_ch_i[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
`ifdef LSU_DEMUX_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef LSU_DEMUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ld_reg    = 1'b0;
        clr_reg   = 1'b0;
        lsu_ack_o = LSU_ACK_IDLE;
`ifdef LSU_DEMUX_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (lsu_req_i.req) begin
                    if (sel == '0) begin
                        state_d = ERR_RESP;
                    end else if ((sel & CH_REG) != '0) begin
                        ld_reg  = 1'b1;
                        sel_d   = sel;
                        state_d = REG_WAIT;
`ifdef LSU_DEMUX_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        lsu_ack_o = ack_comb;
                    end
                end
            end
            REG_WAIT: begin
                if (ack_sel.ack) begin
                    lsu_ack_o = ack_sel;
                    clr_reg   = 1'b1;
                    sel_d     = '0;
                    state_d   = IDLE;
                end
`ifdef LSU_DEMUX_TIMEOUT_EN
                // Watchdog loses to a same-cycle ack; late acks land in IDLE and are ignored.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    clr_reg = 1'b1;
                    sel_d   = '0;
                    state_d = ERR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ERR_RESP: begin
                lsu_ack_o = LSU_ACK_ERR;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE) ||
                    (lsu_req_i.req && ((sel & ~CH_REG) != '0));

    // Per-channel output stage: registered channels hold the captured request until ack.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (CH_REG[i]) begin : g_reg
            lsu_req_t ch_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ch_q <= LSU_REQ_IDLE;
                end else if (clr_reg && sel_q[i]) begin
                    ch_q <= LSU_REQ_IDLE;
                end else if (ld_reg && sel[i]) begin
                    ch_q <= lsu_req_i;
                end
            end
            assign lsu_req_ch_o[i] = ch_q;
        end else begin : g_comb
            assign lsu_req_ch_o[i] = (state_q == IDLE && lsu_req_i.req && sel[i]) ?
                                     lsu_req_i : LSU_REQ_IDLE;
        end
    end

endmodule
